eth_loopback_core: RTL
======================

# eth_loopback_core

Store-and-forward Ethernet loopback engine that terminates the byte-stream interface on the DUT side. It accepts one frame at a time on the input handshake, buffers it in an internal frame RAM, and retransmits it on the output handshake with destination and source MAC addresses swapped. Frames whose length field exceeds the payload limit are consumed and dropped. Forwarded and dropped frames are counted.

## Interface
- MAX_PAYLOAD, 1500, largest accepted payload length in bytes.
- DEPTH, 2048, frame RAM depth in bytes; must be ≥ 14 + MAX_PAYLOAD.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  ingress byte.
- valid_in  input  1  ingress byte valid.
- ready_out  output  1  block can accept an ingress byte.
- data_out  output  8  egress byte.
- valid_out  output  1  egress byte valid.
- ready_in  input  1  downstream accepts the egress byte.
- fwd_count  output  16  frames retransmitted; wraps.
- drop_count  output  16  frames dropped; wraps.

## Operation
- Frame format: bytes 0–5 are DA, 6–11 are SA, 12–13 are payload length L (big-endian), then L payload bytes. Total is 14+L; L=0 is legal.
- An ingress byte transfers on a rising edge with valid_in && ready_out. An egress byte transfers on a rising edge with valid_out && ready_in.
- States:
  - RX_HDR: store bytes 0–13 at addresses 0–13. After byte 13, latch L. If L=0, go to TX. If L>MAX_PAYLOAD, go to DROP. Otherwise go to RX_PAY.
  - RX_PAY: store payload bytes at 14+i. After byte 13+L, go to TX.
  - DROP: consume L bytes without writing the RAM, then increment drop_count and go to RX_HDR.
  - TX: emit 14+L bytes in this order: addresses 6–11, then 0–5, then 12…13+L. After the final transfer, increment fwd_count and go to RX_HDR.
- ready_out is 1 in RX_HDR, RX_PAY and DROP, and 0 in TX. Only one frame is held at a time; there is no RX/TX overlap.
- The byte counter is 16 bits. The compare is against 13+L computed in 17 bits, so L=0xFFFF does not overflow.
- Counters wrap: 0xFFFF + 1 = 0x0000.
- Reset mid-operation: state returns to RX_HDR, any partial or pending frame is discarded, counters clear, and RAM contents are don't-care.

## Timing
- Reset values: ready_out=1 from the first cycle after reset, valid_out=0, data_out=0, fwd_count=0, drop_count=0.
- RAM read latency is 1 cycle. The egress path has an output register plus a one-entry skid so back-to-back transfers run at 1 byte/cycle.
- Last ingress byte accepted at edge T:
  - ready_out=0 from T+1.
  - valid_out=1 with the first byte (SA[0]) from T+2.
- While valid_out=1 and ready_in=0, data_out and valid_out hold stable. valid_out never drops before the byte transfers.
- With ready_in held high, a frame of N bytes completes egress in N consecutive cycles.
- Last egress byte accepted at edge E:
  - valid_out=0 and ready_out=1 from E+1.
  - fwd_count updates at E+1.
- Drop: drop_count updates the cycle after the last dropped byte is accepted, and ready_out stays 1 throughout.
- valid_in low in mid-frame stalls reception with no timeout. Any data_in is ignored while ready_out=0.

## Structure
- Package eth_pkg: HDR_LEN=14, MAC_LEN=6, LEN_HI_IDX=12, state enum {RX_HDR, RX_PAY, DROP, TX}.
- Sub-module eth_frame_ram: simple dual-port RAM, 8 bits × DEPTH, one write port and one registered read port, no reset.
- Top level holds the FSM, the address remap, the egress skid register and the counters.

## Test plan
- 14+4-byte frame with DA=01..06, SA=0A..0F, L=0x0004, payload DE AD BE EF, ready_in=1 → egress 0A..0F 01..06 00 04 DE AD BE EF. valid_out rises 2 cycles after the last input byte; fwd_count=1.
- L=0 frame (14 bytes) → 14 swapped bytes out; ready_out returns 1 the cycle after the last egress transfer.
- L=0x05DD (1501) frame → 1515 bytes consumed with no valid_out; drop_count=1, fwd_count unchanged. A following valid 14-byte frame is forwarded correctly.
- L=1500 frame with ready_in toggling randomly → all 1514 bytes out in order with no duplicates or losses; data_out stable during each stall.
- rst asserted after 20 payload bytes of a 64-byte-payload frame → next cycle valid_out=0, ready_out=1, counters 0. A fresh 18-byte frame is then looped back correctly.
- Preload fwd_count to 0xFFFF by forwarding 65535 L=0 frames (or by a forced preset) → the next forwarded frame wraps it to 0x0000.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and egress address remap for the
// Ethernet loopback core.
package eth_pkg;

  localparam int unsigned HDR_LEN    = 14;
  localparam int unsigned MAC_LEN    = 6;
  localparam int unsigned LEN_HI_IDX = 12;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_PAY,
    DROP,
    TX
  } state_t;

  // Egress byte index -> RAM address: SA first, then DA, then the rest in place.
  function automatic logic [15:0] tx_remap(input logic [15:0] idx);
    if (idx < 16'(MAC_LEN)) begin
      return idx + 16'(MAC_LEN);
    end else if (idx < 16'(2 * MAC_LEN)) begin
      return idx - 16'(MAC_LEN);
    end
    return idx;
  endfunction

endpackage

// File: rtl/eth_loopback_core_if.sv
// Byte-stream ingress/egress handshake bundle for the loopback core.
// The core connects through slave; the traffic source/sink uses master.
interface eth_loopback_core_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;

  modport slave (
    input  data_in,
    input  valid_in,
    input  ready_in,
    output ready_out,
    output data_out,
    output valid_out
  );

  modport master (
    output data_in,
    output valid_in,
    output ready_in,
    input  ready_out,
    input  data_out,
    input  valid_out
  );

endinterface

// File: rtl/eth_frame_ram.sv
// Simple dual-port byte RAM holding one frame: one write port and one
// registered read port, no reset.
module eth_frame_ram #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/eth_loopback_core.sv
// Store-and-forward Ethernet loopback: buffers one frame, retransmits it with
// DA/SA swapped, drops frames whose length field exceeds MAX_PAYLOAD.
module eth_loopback_core
  import eth_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned DEPTH       = 2048
) (
  input  logic                      clk,
  input  logic                      rst,
  eth_loopback_core_if.slave        io,
  output logic [15:0]               fwd_count,
  output logic [15:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rd_idx_q, rd_idx_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        out_v_q, out_v_d;
  logic [7:0]  out_d_q, out_d_d;
  logic        skid_v_q, skid_v_d;
  logic [7:0]  skid_d_q, skid_d_d;
  logic [15:0] fwd_count_q, fwd_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;

  logic          rx_fire;
  logic          pop;
  logic          start_tx;
  logic [15:0]   len_field;
  logic          pay_last;
  logic [16:0]   tx_total;
  logic          rd_done;
  logic          tx_last;
  logic [1:0]    occupancy;
  logic          can_issue;

  eth_frame_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign rx_fire   = io.valid_in && (state_q != TX);
  assign pop       = out_v_q && io.ready_in;
  assign len_field = {len_hi_q, io.data_in};
  assign pay_last  = ({1'b0, byte_cnt_q} + 17'(HDR_LEN)) == (17'(HDR_LEN - 1) + {1'b0, len_q});
  assign tx_total  = 17'(HDR_LEN) + {1'b0, len_q};
  assign rd_done   = {1'b0, rd_idx_q} == tx_total;
  assign tx_last   = ({1'b0, tx_cnt_q} + 17'd1) == tx_total;

  // Bytes held after this cycle (output reg + skid + read in flight); a new
  // read may only be issued if its data will have a slot to land in.
  assign occupancy = 2'(out_v_q) + 2'(skid_v_q) + 2'(rd_pend_q) - 2'(pop);
  assign can_issue = occupancy <= 2'd1;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    rd_idx_d     = rd_idx_q;
    tx_cnt_d     = tx_cnt_q;
    rd_pend_d    = 1'b0;
    out_v_d      = out_v_q;
    out_d_d      = out_d_q;
    skid_v_d     = skid_v_q;
    skid_d_d     = skid_d_q;
    fwd_count_d  = fwd_count_q;
    drop_count_d = drop_count_q;
    start_tx     = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = '0;
    ram_wdata    = io.data_in;
    ram_re       = 1'b0;
    ram_raddr    = '0;

    case (state_q)
      RX_HDR: begin
        if (rx_fire) begin
          ram_we     = 1'b1;
          ram_waddr  = AW'(byte_cnt_q);
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == 16'(LEN_HI_IDX)) begin
            len_hi_d = io.data_in;
          end
          if (byte_cnt_q == 16'(HDR_LEN - 1)) begin
            len_d      = len_field;
            byte_cnt_d = '0;
            if (len_field == '0) begin
              start_tx = 1'b1;
            end else if (len_field > 16'(MAX_PAYLOAD)) begin
              state_d = DROP;
            end else begin
              state_d = RX_PAY;
            end
          end
        end
      end
      RX_PAY: begin
        if (rx_fire) begin
          ram_we     = 1'b1;
          ram_waddr  = AW'(16'(HDR_LEN) + byte_cnt_q);
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (pay_last) begin
            byte_cnt_d = '0;
            start_tx   = 1'b1;
          end
        end
      end
      DROP: begin
        if (rx_fire) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (pay_last) begin
            byte_cnt_d   = '0;
            drop_count_d = drop_count_q + 16'd1;
            state_d      = RX_HDR;
          end
        end
      end
      TX: begin
        if (can_issue && !rd_done) begin
          ram_re    = 1'b1;
          ram_raddr = AW'(tx_remap(rd_idx_q));
          rd_pend_d = 1'b1;
          rd_idx_d  = rd_idx_q + 16'd1;
        end
        if (pop) begin
          tx_cnt_d = tx_cnt_q + 16'd1;
          if (tx_last) begin
            fwd_count_d = fwd_count_q + 16'd1;
            state_d     = RX_HDR;
          end
        end
      end
      default: state_d = RX_HDR;
    endcase

    // First egress read is issued alongside the last ingress byte so SA[0]
    // reaches the output register one cycle after the FSM enters TX.
    if (start_tx) begin
      state_d   = TX;
      ram_re    = 1'b1;
      ram_raddr = AW'(MAC_LEN);
      rd_pend_d = 1'b1;
      rd_idx_d  = 16'd1;
      tx_cnt_d  = '0;
    end

    if (!out_v_q || pop) begin
      if (skid_v_q) begin
        out_v_d  = 1'b1;
        out_d_d  = skid_d_q;
        skid_v_d = rd_pend_q;
        if (rd_pend_q) begin
          skid_d_d = ram_rdata;
        end
      end else if (rd_pend_q) begin
        out_v_d = 1'b1;
        out_d_d = ram_rdata;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      skid_v_d = 1'b1;
      skid_d_d = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_HDR;
      byte_cnt_q   <= '0;
      len_hi_q     <= '0;
      len_q        <= '0;
      rd_idx_q     <= '0;
      tx_cnt_q     <= '0;
      rd_pend_q    <= 1'b0;
      out_v_q      <= 1'b0;
      out_d_q      <= '0;
      skid_v_q     <= 1'b0;
      skid_d_q     <= '0;
      fwd_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      rd_idx_q     <= rd_idx_d;
      tx_cnt_q     <= tx_cnt_d;
      rd_pend_q    <= rd_pend_d;
      out_v_q      <= out_v_d;
      out_d_q      <= out_d_d;
      skid_v_q     <= skid_v_d;
      skid_d_q     <= skid_d_d;
      fwd_count_q  <= fwd_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign io.ready_out = (state_q != TX);
  assign io.valid_out = out_v_q;
  assign io.data_out  = out_d_q;
  assign fwd_count    = fwd_count_q;
  assign drop_count   = drop_count_q;

endmodule
